// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: major opcode constants, the canonical
// NOP encoding, the fetch FSM state encoding and the default reset PC.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch unit: DEPTH entries of {pc, instr}.
// Ports:
//   clk, rst        clock / asynchronous active-high reset (pointers and count)
//   flush           discard all entries; overrides a same-edge push or pop
//   push, push_data write one entry at the tail
//   pop             drop the head entry
//   head_data       current head entry (combinational)
//   count, empty    occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage in front of control_unit. Issues PC-ordered word reads to the
// instruction memory (one request outstanding), buffers returned words and
// presents the head instruction with its decoded register/opcode fields.
// Ports:
//   clk, rst                        clock / asynchronous active-high reset
//   imem_req_valid/addr/ready       fetch request handshake (word aligned)
//   imem_rsp_valid/data             in-order read response
//   redirect_valid/redirect_pc      PC override from branch resolution
//   stall                           downstream holds the current instruction
//   id_valid/id_pc/id_instr         head of the instruction buffer (NOP when empty)
//   opcode/funct3/funct7/rd/rs1/rs2 fields sliced from id_instr
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic [31:0] fetch_pc;   // next address to request
  logic [31:0] req_addr;   // address currently presented to memory
  logic [31:0] req_pc;     // address of the outstanding (accepted) request
  logic        drop;       // outstanding response belongs to a redirected-away path

  logic          accept;
  logic          rsp_take;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_target;
  logic [63:0]   head_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;

  assign accept          = (state_q == FETCH_REQ) && imem_req_ready;
  assign rsp_take        = (state_q == FETCH_WAIT) && imem_rsp_valid;
  assign push            = rsp_take && !drop && !redirect_valid;
  assign pop             = id_valid && !stall && !redirect_valid;
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    case (state_q)
      // Only issue when the word is guaranteed a FIFO slot on return.
      FETCH_IDLE: if (!redirect_valid && (fifo_count < DEPTH_CNT)) state_d = FETCH_REQ;
      FETCH_REQ:  if (imem_req_ready) state_d = FETCH_WAIT;
      FETCH_WAIT: if (imem_rsp_valid) state_d = FETCH_IDLE;
      default:    state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      req_pc   <= RESET_PC;
      drop     <= 1'b0;
    end else begin
      state_q <= state_d;

      // The presented address is latched once so a redirect cannot change it
      // while the request waits for ready.
      if (state_q == FETCH_IDLE && state_d == FETCH_REQ) req_addr <= fetch_pc;
      if (accept) req_pc <= req_addr;

      // An accepted request from a redirected-away path must not advance
      // the new fetch PC.
      if (redirect_valid)        fetch_pc <= redirect_target;
      else if (accept && !drop)  fetch_pc <= fetch_pc + 32'd4;

      if (rsp_take)
        drop <= 1'b0;
      else if (redirect_valid && (state_q == FETCH_REQ || state_q == FETCH_WAIT))
        drop <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({req_pc, imem_rsp_data}),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign imem_req_valid = (state_q == FETCH_REQ);
  assign imem_req_addr  = req_addr;

  assign id_valid = !fifo_empty;
  assign id_pc    = id_valid ? head_data[63:32] : 32'h0;
  assign id_instr = id_valid ? head_data[31:0]  : NOP_INSTR;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign funct3 = id_instr[14:12];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign funct7 = id_instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard of PCs expected to appear on id_* in order.
  logic [31:0] exp_q[$];
  logic [31:0] acc_log[$];
  int          epoch     = 0;
  int          req_epoch = 0;
  int          pops      = 0;
  logic [31:0] exp_next  = 32'h0;
  logic        prev_valid = 1'b0;
  logic        prev_acc   = 1'b0;
  logic [31:0] prev_addr  = 32'h0;
  logic        pend       = 1'b0;
  logic [31:0] pend_addr  = 32'h0;
  logic        mem_hold   = 1'b0;
  logic        force_en   = 1'b0;
  logic        force_val  = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_req_addr"},  64'(imem_req_addr),  64'd0);
    chk({tag, "_id_valid"},  64'(id_valid),       64'd0);
    chk({tag, "_id_pc"},     64'(id_pc),          64'd0);
    chk({tag, "_id_instr"},  64'(id_instr),       64'(NOP));
    chk({tag, "_opcode"},    64'(opcode),         64'h13);
    chk({tag, "_funct3"},    64'(funct3),         64'd0);
    chk({tag, "_funct7"},    64'(funct7),         64'd0);
    chk({tag, "_rd"},        64'(rd),             64'd0);
    chk({tag, "_rs1"},       64'(rs1),            64'd0);
    chk({tag, "_rs2"},       64'(rs2),            64'd0);
  endtask

  // One clock cycle: memory model drives the response, outputs are checked
  // against the scoreboard, the model is updated for the coming edge.
  task automatic cyc();
    logic        acc;
    logic        held;
    logic        rsp;
    logic [31:0] e;
    logic [31:0] w;
    if (force_en) begin
      imem_rsp_valid = force_val;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else begin
      imem_rsp_valid = pend && !mem_hold;
      imem_rsp_data  = pend ? mem_word(pend_addr) : 32'h0;
    end
    rsp  = imem_rsp_valid;
    acc  = imem_req_valid && imem_req_ready;
    held = prev_valid && !prev_acc;

    if (imem_req_valid === 1'b1) begin
      if (held) chk("req_hold", 64'(imem_req_addr), 64'(prev_addr));
      else begin
        chk("req_addr", 64'(imem_req_addr), 64'(exp_next));
        req_epoch = epoch;
      end
    end

    if (id_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("id_unexpected", 64'(id_valid), 64'd0);
      else begin
        e = exp_q[0];
        w = mem_word(e);
        chk("id_pc",    64'(id_pc),    64'(e));
        chk("id_instr", 64'(id_instr), 64'(w));
        chk("opcode",   64'(opcode),   64'(w[6:0]));
        chk("rd",       64'(rd),       64'(w[11:7]));
        chk("funct3",   64'(funct3),   64'(w[14:12]));
        chk("rs1",      64'(rs1),      64'(w[19:15]));
        chk("rs2",      64'(rs2),      64'(w[24:20]));
        chk("funct7",   64'(funct7),   64'(w[31:25]));
        if (!stall && !redirect_valid) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end else begin
      chk("idle_instr",  64'(id_instr), 64'(NOP));
      chk("idle_pc",     64'(id_pc),    64'd0);
      chk("idle_opcode", 64'(opcode),   64'h13);
    end

    if (redirect_valid) begin
      exp_q.delete();
      epoch++;
      exp_next = redirect_pc & ~32'h3;
    end
    if (rsp && !force_en) pend = 1'b0;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      acc_log.push_back(imem_req_addr);
      if (!redirect_valid && req_epoch == epoch) begin
        exp_q.push_back(imem_req_addr);
        exp_next = imem_req_addr + 32'd4;
      end
    end
    prev_valid = imem_req_valid;
    prev_acc   = acc;
    prev_addr  = imem_req_addr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n;
    int          p0;
    logic [31:0] old;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;

    #1 rst = 1'b1;
    #1;
    reset_outputs_chk("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Test 1: sequential fetch after reset release
    n = 0;
    while (pops < 3 && n < 40) begin cyc(); n++; end
    chk("t1_pops_done", 64'(pops >= 3), 64'd1);
    if (acc_log.size() < 3) chk("t1_acc_count", 64'(acc_log.size()), 64'd3);
    else begin
      chk("t1_addr0", 64'(acc_log[0]), 64'h0);
      chk("t1_addr1", 64'(acc_log[1]), 64'h4);
      chk("t1_addr2", 64'(acc_log[2]), 64'h8);
    end

    // Test 2: stall fills the buffer, then release drains in order
    stall = 1'b1;
    repeat (10) cyc();
    chk("t2_req_quiet", 64'(imem_req_valid), 64'd0);
    chk("t2_head_valid", 64'(id_valid), 64'd1);
    stall = 1'b0;
    p0 = pops;
    n = 0;
    while (pops < p0 + 4 && n < 40) begin cyc(); n++; end
    chk("t2_drain", 64'(pops >= p0 + 4), 64'd1);

    // Test 3: redirect while waiting for a response
    n = 0;
    while (!pend && n < 20) begin cyc(); n++; end
    chk("t3_wait_reached", 64'(pend), 64'd1);
    mem_hold = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    cyc();
    mem_hold = 1'b0; redirect_valid = 1'b0;
    cyc();
    chk("t3_id_valid_after", 64'(id_valid), 64'd0);
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("t3_next_req", 64'(imem_req_addr), 64'h100);
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("t3_first_pc", 64'(id_pc), 64'h100);

    // Test 4: redirect to unaligned PC while the request is held off
    imem_req_ready = 1'b0;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    old = imem_req_addr;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    cyc();
    chk("t4_req_held_valid", 64'(imem_req_valid), 64'd1);
    chk("t4_req_held_addr", 64'(imem_req_addr), 64'(old));
    imem_req_ready = 1'b1;
    cyc();
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("t4_next_req", 64'(imem_req_addr), 64'h200);
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("t4_first_pc", 64'(id_pc), 64'h200);

    // Test 5: redirect coinciding with a response and a pop
    stall = 1'b1;
    n = 0;
    while (!(pend && id_valid === 1'b1) && n < 20) begin cyc(); n++; end
    chk("t5_setup", 64'(pend && id_valid === 1'b1), 64'd1);
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
    cyc();
    redirect_valid = 1'b0;
    chk("t5_fifo_empty", 64'(id_valid), 64'd0);
    chk("t5_nop", 64'(id_instr), 64'(NOP));
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("t5_first_pc", 64'(id_pc), 64'h300);

    // Test 6: reset while a response is outstanding; stale responses ignored
    n = 0;
    while (!pend && n < 20) begin cyc(); n++; end
    chk("t6_wait_reached", 64'(pend), 64'd1);
    mem_hold = 1'b1;
    rst = 1'b1;
    #1;
    reset_outputs_chk("t6_reset");
    pend = 1'b0; exp_q.delete(); epoch++; exp_next = 32'h0;
    prev_valid = 1'b0; prev_acc = 1'b0;
    force_en = 1'b1; force_val = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("t6_id_valid_after_stale", 64'(id_valid), 64'd0);
    force_en = 1'b0; mem_hold = 1'b0;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("t6_first_req", 64'(imem_req_addr), 64'h0);
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin cyc(); n++; end
    chk("t6_first_pc", 64'(id_pc), 64'h0);
    repeat (6) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
